// File: rtl/digit_entry_pkg.sv
// digit_entry_pkg
// Shared types and constants for the digit entry front-panel controller.
// Contents:
//   MAX_DIGITS                 - largest supported digit count
//   DEFAULT_BLINK_HALF_PERIOD  - default cycles per blink on/off phase
//   key_events_t               - one-cycle key press events, one bit per key
//   commit_state_t             - state of the commit valid/ready handshake
package digit_entry_pkg;

    localparam int MAX_DIGITS                = 8;
    localparam int DEFAULT_BLINK_HALF_PERIOD = 25_000_000;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic enter;
    } key_events_t;

    typedef enum logic {
        COMMIT_IDLE,
        COMMIT_PENDING
    } commit_state_t;

endpackage

// File: rtl/risingedge_detector.sv
// risingedge_detector
// Turns a raw key level into a single-cycle pulse on each 0->1 transition.
// The level is registered first, so the pulse is purely a decode of flops.
// Ports:
//   clock  - system clock
//   reset  - asynchronous, active-high reset
//   signal - raw input level
//   pulse  - high for one cycle after signal is first sampled high
module risingedge_detector (
    input  logic clock,
    input  logic reset,
    input  logic signal,
    output logic pulse
);

    logic sampled;
    logic previous;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sampled  <= 1'b0;
            previous <= 1'b0;
        end else begin
            sampled  <= signal;
            previous <= sampled;
        end
    end

    assign pulse = sampled & ~previous;

endmodule

// File: rtl/seven_segments_hex.sv
// seven_segments_hex
// Hex nibble to 7-segment decoder, active-high, bit order {dp,g,f,e,d,c,b,a}.
// The decimal point is always off.
// Ports:
//   hex      - nibble to show
//   segments - segment pattern
module seven_segments_hex (
    input  logic [3:0] hex,
    output logic [7:0] segments
);

    always_comb begin
        segments = 8'h00;
        case (hex)
            4'h0: segments = 8'h3F;
            4'h1: segments = 8'h06;
            4'h2: segments = 8'h5B;
            4'h3: segments = 8'h4F;
            4'h4: segments = 8'h66;
            4'h5: segments = 8'h6D;
            4'h6: segments = 8'h7D;
            4'h7: segments = 8'h07;
            4'h8: segments = 8'h7F;
            4'h9: segments = 8'h6F;
            4'hA: segments = 8'h77;
            4'hB: segments = 8'h7C;
            4'hC: segments = 8'h39;
            4'hD: segments = 8'h5E;
            4'hE: segments = 8'h79;
            4'hF: segments = 8'h71;
            default: segments = 8'h00;
        endcase
    end

endmodule

// File: rtl/digit_entry_controller.sv
// digit_entry_controller
// Multi-digit hex entry from panel keys: up/down edit the digit under the
// cursor, left/right move the cursor, enter commits the whole value over a
// valid/ready handshake. Each digit drives one 7-segment pattern.
// Optional feature macro: DIGIT_ENTRY_BLINK_EN - blank the active digit
// during the off phase of a blink counter.
// Ports:
//   clock, reset                    - system clock, async active-high reset
//   up_key, down_key                - raw key levels, edit the active digit
//   left_key, right_key             - raw key levels, move the cursor
//   enter_key                       - raw key level, commit the value
//   display[8*NUM_DIGITS-1:0]       - segment patterns, digit i at [8i+7:8i]
//   cursor                          - active digit index, 0 = LSD
//   edit_value[4*NUM_DIGITS-1:0]    - live digit registers
//   value_out[4*NUM_DIGITS-1:0]     - committed value
//   value_valid / value_ready       - commit handshake
module digit_entry_controller
    import digit_entry_pkg::*;
#(
    parameter int          NUM_DIGITS        = 4,
    parameter int          BLINK_HALF_PERIOD = DEFAULT_BLINK_HALF_PERIOD,
    parameter logic [7:0]  BLANK_SEG         = 8'h00,
    localparam int         CURSOR_W          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      up_key,
    input  logic                      down_key,
    input  logic                      left_key,
    input  logic                      right_key,
    input  logic                      enter_key,
    output logic [8*NUM_DIGITS-1:0]   display,
    output logic [CURSOR_W-1:0]       cursor,
    output logic [4*NUM_DIGITS-1:0]   edit_value,
    output logic [4*NUM_DIGITS-1:0]   value_out,
    output logic                      value_valid,
    input  logic                      value_ready
);

    localparam bit CONFIG_OK = (NUM_DIGITS >= 1) && (NUM_DIGITS <= MAX_DIGITS)
                               && (BLINK_HALF_PERIOD >= 2);
    localparam logic [CURSOR_W-1:0] LAST_DIGIT = CURSOR_W'(NUM_DIGITS - 1);

    generate
        if (!CONFIG_OK) begin : g_bad_config
            $error("digit_entry_controller: NUM_DIGITS or BLINK_HALF_PERIOD out of range");
        end
    endgenerate

    logic up_event, down_event, left_event, right_event, enter_event;
    key_events_t events;

    risingedge_detector u_up_edge    (.clock(clock), .reset(reset), .signal(up_key),    .pulse(up_event));
    risingedge_detector u_down_edge  (.clock(clock), .reset(reset), .signal(down_key),  .pulse(down_event));
    risingedge_detector u_left_edge  (.clock(clock), .reset(reset), .signal(left_key),  .pulse(left_event));
    risingedge_detector u_right_edge (.clock(clock), .reset(reset), .signal(right_key), .pulse(right_event));
    risingedge_detector u_enter_edge (.clock(clock), .reset(reset), .signal(enter_key), .pulse(enter_event));

    assign events = '{up: up_event, down: down_event, left: left_event,
                      right: right_event, enter: enter_event};

    logic [NUM_DIGITS-1:0][3:0] digits;
    commit_state_t commit_state;
    commit_state_t commit_next;
    logic          capture_value;
    logic          blink_off;

    // Up has priority over down when both keys fire together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            digits <= '0;
        end else if (events.up) begin
            digits[cursor] <= digits[cursor] + 4'd1;
        end else if (events.down) begin
            digits[cursor] <= digits[cursor] - 4'd1;
        end
    end

    // Opposing moves cancel. Wrapping is explicit so non power-of-two
    // digit counts stay inside the valid range.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cursor <= '0;
        end else if (events.left && !events.right) begin
            cursor <= (cursor == LAST_DIGIT) ? '0 : cursor + 1'b1;
        end else if (events.right && !events.left) begin
            cursor <= (cursor == '0) ? LAST_DIGIT : cursor - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            commit_state <= COMMIT_IDLE;
        end else begin
            commit_state <= commit_next;
        end
    end

    // An enter while pending (including the transfer edge) is dropped,
    // which rules out back-to-back commits.
    always_comb begin
        commit_next = commit_state;
        case (commit_state)
            COMMIT_IDLE:    if (events.enter) commit_next = COMMIT_PENDING;
            COMMIT_PENDING: if (value_ready)  commit_next = COMMIT_IDLE;
            default:        commit_next = COMMIT_IDLE;
        endcase
    end

    always_comb begin
        value_valid   = (commit_state == COMMIT_PENDING);
        capture_value = (commit_state == COMMIT_IDLE) && events.enter;
    end

    // Captures the registers before this edge's edit lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value_out <= '0;
        end else if (capture_value) begin
            value_out <= digits;
        end
    end

`ifdef DIGIT_ENTRY_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_HALF_PERIOD);

    logic [BLINK_W-1:0] blink_count;
    logic               blink_on;
    logic               blink_restart;

    assign blink_restart = events.up | events.down | events.left | events.right;

    // Any edit or move restarts the on phase so the change shows at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_count <= '0;
            blink_on    <= 1'b1;
        end else if (blink_restart) begin
            blink_count <= '0;
            blink_on    <= 1'b1;
        end else if (blink_count == BLINK_W'(BLINK_HALF_PERIOD - 1)) begin
            blink_count <= '0;
            blink_on    <= ~blink_on;
        end else begin
            blink_count <= blink_count + 1'b1;
        end
    end

    assign blink_off = ~blink_on;
`else
    assign blink_off = 1'b0;
`endif

    assign edit_value = digits;

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            logic [7:0] pattern;

            seven_segments_hex u_segments (.hex(digits[i]), .segments(pattern));

            assign display[8*i +: 8] = (blink_off && cursor == CURSOR_W'(i)) ? BLANK_SEG : pattern;
        end
    endgenerate

endmodule

// File: tb/tb_digit_entry_controller.sv
// tb_digit_entry_controller
// Directed steps from the test plan followed by random key traffic, all
// compared each cycle against a behavioural model of the panel.
module tb_digit_entry_controller;

    localparam int         N     = 4;
    localparam int         W     = 4 * N;
    localparam int         HALF  = 4;
    localparam logic [7:0] BLANK = 8'h00;

    localparam logic [4:0] K_UP    = 5'b10000;
    localparam logic [4:0] K_DOWN  = 5'b01000;
    localparam logic [4:0] K_LEFT  = 5'b00100;
    localparam logic [4:0] K_RIGHT = 5'b00010;
    localparam logic [4:0] K_ENTER = 5'b00001;

    logic           clock;
    logic           reset;
    logic           up_key, down_key, left_key, right_key, enter_key;
    logic [8*N-1:0] display;
    logic [1:0]     cursor;
    logic [W-1:0]   edit_value;
    logic [W-1:0]   value_out;
    logic           value_valid;
    logic           value_ready;

    digit_entry_controller #(
        .NUM_DIGITS       (N),
        .BLINK_HALF_PERIOD(HALF),
        .BLANK_SEG        (BLANK)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .up_key     (up_key),
        .down_key   (down_key),
        .left_key   (left_key),
        .right_key  (right_key),
        .enter_key  (enter_key),
        .display    (display),
        .cursor     (cursor),
        .edit_value (edit_value),
        .value_out  (value_out),
        .value_valid(value_valid),
        .value_ready(value_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int    check_count = 0;
    int    pass_count  = 0;
    int    fail_count  = 0;
    string step_name   = "init";

    // Behavioural model state
    int           m_digit[N];
    int           m_cursor;
    logic [W-1:0] m_vout;
    bit           m_valid;
    int           m_since_change;
    logic [4:0]   key_last;
    logic [4:0]   key_before;

    function automatic logic [7:0] seg_of(input int v);
        logic [7:0] table_seg[16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
        return table_seg[v % 16];
    endfunction

    function automatic logic [W-1:0] model_value();
        logic [W-1:0] v = '0;
        for (int i = 0; i < N; i++) v[4*i +: 4] = 4'(m_digit[i]);
        return v;
    endfunction

    function automatic logic [8*N-1:0] model_display();
        logic [8*N-1:0] d = '0;
        bit blink_on = 1'b1;
`ifdef DIGIT_ENTRY_BLINK_EN
        blink_on = ((m_since_change / HALF) % 2) == 0;
`endif
        for (int i = 0; i < N; i++)
            d[8*i +: 8] = (!blink_on && i == m_cursor) ? BLANK : seg_of(m_digit[i]);
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_digit[i] = 0;
        m_cursor       = 0;
        m_vout         = '0;
        m_valid        = 1'b0;
        m_since_change = 0;
        key_last       = '0;
        key_before     = '0;
    endtask

    // Presses register at one edge and act at the following one.
    task automatic model_edge();
        logic [4:0]   keys = {up_key, down_key, left_key, right_key, enter_key};
        logic [4:0]   ev   = key_last & ~key_before;
        logic [W-1:0] before_edit = model_value();
        if (ev[4])      m_digit[m_cursor] = (m_digit[m_cursor] + 1) % 16;
        else if (ev[3]) m_digit[m_cursor] = (m_digit[m_cursor] + 15) % 16;
        if (ev[2] && !ev[1]) m_cursor = (m_cursor + 1) % N;
        if (ev[1] && !ev[2]) m_cursor = (m_cursor + N - 1) % N;
        if (m_valid) begin
            if (value_ready) m_valid = 1'b0;
        end else if (ev[0]) begin
            m_vout  = before_edit;
            m_valid = 1'b1;
        end
        if (|ev[4:1]) m_since_change = 0;
        else          m_since_change++;
        key_before = key_last;
        key_last   = keys;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        assert (observed === expected) begin
            pass_count++;
        end else begin
            fail_count++;
            $error("[TB] FAIL %s/%s observed=%0h expected=%0h", step_name, tag, observed, expected);
        end
    endtask

    task automatic check_model();
        checkOutput("edit_value",  64'(edit_value),  64'(model_value()));
        checkOutput("cursor",      64'(cursor),      64'(m_cursor));
        checkOutput("value_out",   64'(value_out),   64'(m_vout));
        checkOutput("value_valid", 64'(value_valid), 64'(m_valid));
        checkOutput("display",     64'(display),     64'(model_display()));
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_reset();
        else       model_edge();
        #1;
        check_model();
    endtask

    task automatic applyStimulus(input logic [4:0] keys);
        {up_key, down_key, left_key, right_key, enter_key} = keys;
    endtask

    task automatic press(input logic [4:0] keys);
        applyStimulus(keys);
        tick();
        applyStimulus(5'b0);
        tick();
    endtask

    task automatic do_reset();
        applyStimulus(5'b0);
        value_ready = 1'b0;
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        applyStimulus(5'b0);
        value_ready = 1'b0;
        reset       = 1'b1;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        step_name = "reset";
        checkOutput("edit_value", 64'(edit_value), 64'h0);
        checkOutput("display",    64'(display),    64'h3F3F3F3F);
        checkOutput("valid",      64'(value_valid), 64'h0);

        step_name = "up3";
        repeat (3) press(K_UP);
        checkOutput("edit_value", 64'(edit_value), 64'h0003);
        checkOutput("cursor",     64'(cursor),     64'h0);

        step_name = "down4";
        repeat (4) press(K_DOWN);
        checkOutput("edit_value", 64'(edit_value), 64'h000F);

        step_name = "left_wrap";
        for (int i = 1; i <= 4; i++) begin
            press(K_LEFT);
            checkOutput("cursor", 64'(cursor), 64'(i % 4));
        end
        step_name = "right_wrap";
        press(K_RIGHT);
        checkOutput("cursor", 64'(cursor), 64'h3);

        step_name = "left_hold";
        applyStimulus(K_LEFT);
        repeat (100) tick();
        applyStimulus(5'b0);
        tick();
        checkOutput("cursor", 64'(cursor), 64'h0);

        step_name = "up_left";
        do_reset();
        repeat (2) press(K_UP);
        press(K_UP | K_LEFT);
        checkOutput("edit_value", 64'(edit_value), 64'h0003);
        checkOutput("cursor",     64'(cursor),     64'h1);
        step_name = "up_down";
        press(K_UP | K_DOWN);
        checkOutput("edit_value", 64'(edit_value), 64'h0013);

        step_name = "build_12AB";
        do_reset();
        repeat (5) press(K_DOWN);
        press(K_LEFT);
        repeat (6) press(K_DOWN);
        press(K_LEFT);
        repeat (2) press(K_UP);
        press(K_LEFT);
        press(K_UP);
        checkOutput("edit_value", 64'(edit_value), 64'h12AB);

        step_name = "commit";
        press(K_ENTER);
        checkOutput("valid",     64'(value_valid), 64'h1);
        checkOutput("value_out", 64'(value_out),   64'h12AB);
        repeat (3) press(K_RIGHT);
        press(K_UP);
        press(K_ENTER);
        checkOutput("edit_value", 64'(edit_value), 64'h12AC);
        checkOutput("value_out",  64'(value_out),  64'h12AB);
        checkOutput("valid",      64'(value_valid), 64'h1);
        value_ready = 1'b1;
        tick();
        checkOutput("valid_drop", 64'(value_valid), 64'h0);
        value_ready = 1'b0;

        step_name = "reset_mid_handshake";
        press(K_ENTER);
        checkOutput("valid",     64'(value_valid), 64'h1);
        checkOutput("value_out", 64'(value_out),   64'h12AC);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checkOutput("valid",     64'(value_valid), 64'h0);
        checkOutput("value_out", 64'(value_out),   64'h0);
        checkOutput("cursor",    64'(cursor),      64'h0);
        check_model();
        tick();
        reset = 1'b0;

`ifdef DIGIT_ENTRY_BLINK_EN
        step_name = "blink";
        repeat (12) tick();
        press(K_UP);
        checkOutput("restart", 64'(display[7:0]), 64'(seg_of(1)));
`endif

        step_name = "random";
        repeat (400) begin
            applyStimulus({($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                           ($urandom_range(0, 3) == 0)});
            value_ready = ($urandom_range(0, 1) == 1);
            tick();
        end
        applyStimulus(5'b0);
        value_ready = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/digit_entry_controller.md
# digit_entry_controller

- Multi-digit hexadecimal entry controller for the board's key/7-segment front panel.
- Holds NUM_DIGITS nibble registers and a cursor. Up/down edit the digit under the cursor; left/right move the cursor.
- An enter press commits the full value to downstream logic over a valid/ready handshake.
- Drives one 7-segment pattern per digit; the active digit optionally blinks. Sits between the panel keys and any datapath needing an operand.

## Interface
- NUM_DIGITS, 4 — number of nibble digits (1..8); value width is 4*NUM_DIGITS.
- BLINK_HALF_PERIOD, 25_000_000 — clock cycles per blink on/off phase (≥2).
- BLANK_SEG, 8'h00 — segment pattern driven for a blanked digit.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- up_key  in  1  raw key level; increments the active digit.
- down_key  in  1  raw key level; decrements the active digit.
- left_key  in  1  raw key level; moves the cursor toward the MSD.
- right_key  in  1  raw key level; moves the cursor toward the LSD.
- enter_key  in  1  raw key level; commits the value.
- display  out  8*NUM_DIGITS  segment patterns; digit i at [8i+7:8i].
- cursor  out  $clog2(NUM_DIGITS) (min 1)  index of the active digit; 0 = LSD.
- edit_value  out  4*NUM_DIGITS  live digit registers; digit i at [4i+3:4i].
- value_out  out  4*NUM_DIGITS  committed value; stable while value_valid is high.
- value_valid  out  1  commit pending.
- value_ready  in  1  consumer accepts the commit.

## Operation
- Each key passes through its own risingedge_detector. Only a 0→1 transition produces a one-cycle event; holding a key produces exactly one event.
- Edit:
  - up event: digit[cursor] += 1, mod 16 (F→0).
  - down event: digit[cursor] −= 1, mod 16 (0→F).
  - up and down events in the same cycle: up wins, down is dropped.
- Cursor:
  - left: cursor+1, wraps NUM_DIGITS−1→0.
  - right: cursor−1, wraps 0→NUM_DIGITS−1.
  - left and right in the same cycle: no move.
- Edit and move in the same cycle: the edit applies to the pre-move cursor digit; the cursor moves on the same edge.
- Commit handshake:
  - enter event while value_valid=0: value_out ← edit_value as it was before this cycle's edit; value_valid←1.
  - enter event while value_valid=1: ignored; value_out unchanged.
  - Transfer completes on any edge with value_valid=1 and value_ready=1; value_valid←0 on that edge.
  - value_ready is ignored while value_valid=0.
  - enter on the same edge as a transfer completes is ignored (no back-to-back commit).
- Editing and cursor moves stay enabled while a commit is pending; value_out is unaffected.
- Display: non-active digits always show seven_segments_hex(digit). The active digit follows Configuration.
- Reset (any time, including mid-handshake): all digits 0, cursor 0, value_out 0, value_valid 0, blink phase on, blink counter 0, edge detectors cleared. display shows "0" on every digit.

## Timing
- A key first sampled high at edge k gives an event during cycle k..k+1. The register, cursor or value_valid update lands at edge k+1. display/edit_value reflect the change combinationally after k+1.
- value_valid rises at edge k+1 after an enter key is sampled at k. It falls on the handshake edge. Minimum valid width is 1 cycle if ready is already high.
- All outputs are registered state or combinational decode of registered state; no input→output combinational path (value_ready affects only next state).

## Configuration
- DIGIT_ENTRY_BLINK_EN defined:
  - Blink counter counts 0..BLINK_HALF_PERIOD−1, then toggles phase.
  - Active digit shows BLANK_SEG during the off phase.
  - Any edit or cursor-move event resets the counter to 0 and the phase to on, so a change is visible immediately.
- DIGIT_ENTRY_BLINK_EN not defined: no counter is built; the active digit is always displayed. The cursor is visible only via the cursor port.

## Structure
- Package digit_entry_pkg:
  - typedef key_events_t (struct of up, down, left, right, enter event bits).
  - constants MAX_DIGITS=8 and default BLINK_HALF_PERIOD.
- Reuses existing risingedge_detector (×5) and seven_segments_hex (×NUM_DIGITS). No new sub-module.
- Digits form a packed register array indexed by cursor.

## Test plan
- Reset, then up ×3 at cursor 0 → edit_value=16'h0003, cursor=0. down ×4 → 16'hFFFF... no: digit0=F, edit_value=16'h000F.
- left ×4 from cursor 0 → cursor 1,2,3,0 (wrap). right once from 0 → cursor 3. Holding left 100 cycles → exactly one move.
- Up and left in the same cycle at cursor 0 with digit0=2 → digit0=3, cursor=1. Up+down together → +1 only.
- Enter with edit_value=16'h12AB, value_ready=0 → value_valid=1, value_out=16'h12AB. Edit digit0 and press enter again → value_out unchanged. Raise ready → valid falls after 1 edge.
- Reset asserted mid-handshake (valid=1) → valid=0, value_out=0, cursor=0 immediately (asynchronous).
- BLINK_EN with BLINK_HALF_PERIOD=4 → active digit alternates pattern/BLANK_SEG every 4 cycles. An up event restarts the on phase.
